// File: rtl/spart_pkg.sv
// Shared definitions for the SPART sequencer.
//   state_t    : sequencer states (divisor low byte, divisor high byte, echo run)
//   ADDR_*     : SPART register addresses driven on ioaddr
//   DIV_TABLE  : baud divisor per br_cfg code (00=4800 .. 11=38400)
//   divisor_for: table lookup helper
package spart_pkg;

    typedef enum logic [1:0] {
        CFG_LO = 2'd0,
        CFG_HI = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Entry [0] is the rightmost element of the concatenation.
    localparam logic [3:0][15:0] DIV_TABLE = {
        16'h00A2,   // 11: 38400
        16'h0145,   // 10: 19200
        16'h028A,   // 01:  9600
        16'h0515    // 00:  4800
    };

    function automatic logic [15:0] divisor_for(input logic [1:0] sel);
        return DIV_TABLE[sel];
    endfunction

endpackage

// File: rtl/spart_seq_if.sv
// SPART bus control/status signals (the data bus stays a separate inout port).
//   iocs   : chip select, high during a bus access cycle
//   iorw   : 1 = read from SPART, 0 = write to SPART
//   ioaddr : SPART register address
//   rda    : SPART receive data available
//   tbr    : SPART transmit buffer ready
// master = sequencer side, slave = SPART side.
interface spart_seq_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);

endinterface

// File: rtl/spart_seq_echo_fifo.sv
// echo_fifo: byte FIFO holding received bytes until they are echoed back.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write din when not full
//   pop, dout  : dout shows the head; pop advances it when not empty
//   full, empty, level : occupancy flags and count 0..DEPTH
// DEPTH must be a power of two in 2..16 so the pointers wrap for free.
module echo_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [4:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array is deliberately left out of reset; emptiness is
    // tracked by count, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 5'(DEPTH));
    assign empty = (count == 5'd0);
    assign level = count;

endmodule

// File: rtl/spart_seq.sv
// spart_seq: configures a SPART's baud divisor from br_cfg, then echoes every
// received byte back out through a small FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   br_cfg      : baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   bus         : spart_seq_if master (iocs, iorw, ioaddr out; rda, tbr in)
//   databus     : SPART data bus, driven only on write cycles, else high-Z
//   cfg_done    : divisor for the current br_cfg has been loaded
//   fifo_level  : echo buffer occupancy
module spart_seq
    import spart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  br_cfg,
    spart_seq_if.master bus,
    inout  wire  [7:0]  databus,
    output logic        cfg_done,
    output logic [4:0]  fifo_level
);

    state_t      state;
    state_t      next_state;
    logic [1:0]  br_q;        // br_cfg sampled every cycle
    logic [1:0]  cfg_sel;     // br_cfg value whose divisor is being / was loaded
    logic        rd_hold;     // read issued last cycle
    logic        wr_hold;     // write issued last cycle
    logic        rd_ok;
    logic        wr_ok;
    logic        cfg_change;
    logic        do_rd;
    logic        do_wr;
    logic        drive;
    logic [7:0]  drive_data;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    logic [15:0] cur_div;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    // CFG_LO takes the live br_cfg so the first cycle after reset already
    // loads the right divisor; CFG_HI must finish the value CFG_LO started.
    assign cur_div    = divisor_for((state == CFG_LO) ? br_cfg : cfg_sel);
    assign cfg_change = (br_q != cfg_sel);

    // Holdoffs give the SPART a cycle to drop rda/tbr after an access.
    assign rd_ok = bus.rda && !fifo_full && !rd_hold;
    assign wr_ok = bus.tbr && !fifo_empty && !wr_hold;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        iocs       = 1'b0;
        iorw       = 1'b1;
        ioaddr     = ADDR_STAT;
        drive      = 1'b0;
        drive_data = 8'h00;
        do_rd      = 1'b0;
        do_wr      = 1'b0;
        // Outputs are forced idle while reset is held so an interrupted
        // access is released at once, not at the next edge.
        if (rst_n) begin
            case (state)
                CFG_LO: begin
                    iocs       = 1'b1;
                    iorw       = 1'b0;
                    ioaddr     = ADDR_DBL;
                    drive      = 1'b1;
                    drive_data = cur_div[7:0];
                    next_state = CFG_HI;
                end
                CFG_HI: begin
                    iocs       = 1'b1;
                    iorw       = 1'b0;
                    ioaddr     = ADDR_DBH;
                    drive      = 1'b1;
                    drive_data = cur_div[15:8];
                    next_state = (br_cfg != cfg_sel) ? CFG_LO : RUN;
                end
                RUN: begin
                    if (cfg_change) begin
                        next_state = CFG_LO;
                    end else if (rd_ok) begin
                        do_rd  = 1'b1;
                        iocs   = 1'b1;
                        iorw   = 1'b1;
                        ioaddr = ADDR_BUF;
                    end else if (wr_ok) begin
                        do_wr      = 1'b1;
                        iocs       = 1'b1;
                        iorw       = 1'b0;
                        ioaddr     = ADDR_BUF;
                        drive      = 1'b1;
                        drive_data = fifo_dout;
                    end
                end
                default: next_state = CFG_LO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CFG_LO;
            br_q     <= 2'b00;
            cfg_sel  <= 2'b00;
            cfg_done <= 1'b0;
            rd_hold  <= 1'b0;
            wr_hold  <= 1'b0;
        end else begin
            state    <= next_state;
            br_q     <= br_cfg;
            if (state == CFG_LO) begin
                cfg_sel <= br_cfg;
            end
            cfg_done <= (next_state == RUN);
            rd_hold  <= do_rd;
            wr_hold  <= do_wr;
        end
    end

    assign bus.iocs   = iocs;
    assign bus.iorw   = iorw;
    assign bus.ioaddr = ioaddr;
    assign databus    = drive ? drive_data : 8'hzz;

    echo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (do_rd),
        .pop   (do_wr),
        .din   (databus),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_spart_seq.sv
// Testbench for spart_seq: a behavioural SPART model feeds bytes and accepts
// writes; every byte offered is queued as an expected echo and a negedge
// monitor checks each bus cycle against that queue and a simple access model.
module tb_spart_seq;

    localparam int DEPTH = 4;

    typedef enum int {K_IDLE, K_RD, K_WR, K_LO, K_HI, K_BAD} kind_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic       cfg_done;
    logic [4:0] fifo_level;
    wire  [7:0] databus;

    spart_seq_if bus ();

    spart_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_cfg     (br_cfg),
        .bus        (bus),
        .databus    (databus),
        .cfg_done   (cfg_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // SPART model state
    logic       rda_drv;
    logic       tbr_drv;
    logic [7:0] rx_byte;
    logic       tbr_en;
    logic [7:0] rx_q[$];     // bytes the SPART still has to hand over
    logic [7:0] exp_q[$];    // bytes expected to be echoed, in order

    assign bus.rda = rda_drv;
    assign bus.tbr = tbr_drv;
    assign databus = (bus.iocs && bus.iorw) ? rx_byte : 8'hzz;

    // Model / monitor state
    logic mon_en;
    logic pop_pending;
    logic prev_rd;
    logic prev_wr;
    logic run_model;
    logic saw_lo;
    logic cfg_due;
    int   model_level;
    int   cfg_writes;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Baud divisor from a 100 MHz clock with 16x oversampling, rounded, minus one.
    function automatic logic [15:0] div_model(input logic [1:0] sel);
        int baud;
        baud = 4800 << sel;
        return 16'((100_000_000 + 8 * baud) / (16 * baud) - 1);
    endfunction

    function automatic kind_t classify();
        if (!bus.iocs && bus.iorw && bus.ioaddr == 2'b01) return K_IDLE;
        if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00)  return K_RD;
        if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) return K_WR;
        if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b10) return K_LO;
        if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b11) return K_HI;
        return K_BAD;
    endfunction

    task automatic flush();
        rx_q.delete();
        exp_q.delete();
        model_level = 0;
        pop_pending = 1'b0;
        prev_rd     = 1'b0;
        prev_wr     = 1'b0;
        run_model   = 1'b0;
        saw_lo      = 1'b0;
        cfg_due     = 1'b0;
        rda_drv     = 1'b0;
        tbr_drv     = 1'b0;
        rx_byte     = 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // Monitor: settle inputs at negedge, then judge the access that will
    // complete at the coming posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            kind_t      kind;
            kind_t      exp_kind;
            logic [15:0] d;
            if (pop_pending) begin
                rx_q.delete(0);
                pop_pending = 1'b0;
            end
            check("fifo_level", int'(fifo_level), model_level);
            if (cfg_due) begin
                check("cfg_done after cfg", int'(cfg_done), 1);
                cfg_due = 1'b0;
            end
            rda_drv = (rx_q.size() != 0);
            tbr_drv = tbr_en;
            rx_byte = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
            #1;
            kind = classify();
            if (run_model) begin
                exp_kind = K_IDLE;
                if (rda_drv && model_level < DEPTH && !prev_rd)
                    exp_kind = K_RD;
                else if (tbr_drv && model_level > 0 && !prev_wr)
                    exp_kind = K_WR;
                check("access kind", int'(kind), int'(exp_kind));
            end
            d = div_model(br_cfg);
            case (kind)
                K_RD: begin
                    model_level++;
                    pop_pending = 1'b1;
                end
                K_WR: begin
                    if (exp_q.size() == 0) begin
                        check("write with nothing expected", int'(databus), -1);
                    end else begin
                        check("echo data", int'(databus), int'(exp_q[0]));
                        exp_q.delete(0);
                    end
                    model_level--;
                end
                K_LO: begin
                    check("cfg lo data", int'(databus), int'(d[7:0]));
                    check("cfg_done low in CFG_LO", int'(cfg_done), 0);
                    saw_lo    = 1'b1;
                    run_model = 1'b0;
                    cfg_writes++;
                end
                K_HI: begin
                    check("cfg hi after lo", int'(saw_lo), 1);
                    check("cfg hi data", int'(databus), int'(d[15:8]));
                    check("cfg_done low in CFG_HI", int'(cfg_done), 0);
                    saw_lo    = 1'b0;
                    run_model = 1'b1;
                    cfg_due   = 1'b1;
                    cfg_writes++;
                end
                K_BAD: check("bus encoding", int'({bus.iocs, bus.iorw, bus.ioaddr}), 4'b0101);
                default: ;
            endcase
            prev_rd = (kind == K_RD);
            prev_wr = (kind == K_WR);
        end
    end

    task automatic release_reset();
        logic [15:0] d;
        d = div_model(br_cfg);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        flush();
        mon_en = 1'b1;
        @(negedge clk);
        #2;
        check("first cycle is CFG_LO", int'(classify()), int'(K_LO));
        check("first cycle data", int'(databus), int'(d[7:0]));
        @(negedge clk);
        #2;
        check("second cycle is CFG_HI", int'(classify()), int'(K_HI));
        check("second cycle data", int'(databus), int'(d[15:8]));
        @(negedge clk);
        #2;
        check("cfg_done after release", int'(cfg_done), 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || rx_q.size() != 0); i++) begin
            @(negedge clk);
            #3;
        end
        repeat (2) @(negedge clk);
        #3;
        check("drain complete", exp_q.size(), 0);
        check("fifo empty after drain", int'(fifo_level), 0);
    endtask

    task automatic wait_level(input int n, input int budget);
        for (int i = 0; i < budget && model_level != n; i++) begin
            @(negedge clk);
            #3;
        end
        repeat (2) @(negedge clk);
        #3;
        check("fifo level reached", int'(fifo_level), n);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cw0;
        rst_n      = 1'b0;
        br_cfg     = 2'b01;
        tbr_en     = 1'b0;
        mon_en     = 1'b0;
        cfg_writes = 0;
        flush();
        #2;
        check("reset iocs", int'(bus.iocs), 0);
        check("reset cfg_done", int'(cfg_done), 0);
        check("reset fifo_level", int'(fifo_level), 0);
        repeat (2) @(posedge clk);
        release_reset();

        // Single byte echo
        @(negedge clk);
        #3;
        tbr_en = 1'b1;
        push_byte(8'h41);
        wait_drain(50);

        // Fill to full with transmitter blocked, fifth byte stays pending
        tbr_en = 1'b0;
        for (int b = 1; b <= 5; b++) push_byte(8'(b));
        wait_level(DEPTH, 60);
        repeat (4) @(negedge clk);
        #3;
        check("full level held", int'(fifo_level), DEPTH);
        check("fifth byte still pending", rx_q.size(), 1);
        tbr_en = 1'b1;
        wait_drain(100);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            #3;
            if (rx_q.size() < 3 && $urandom_range(0, 2) == 0) push_byte(8'($urandom));
            if ($urandom_range(0, 7) == 0) tbr_en = ~tbr_en;
        end
        tbr_en = 1'b1;
        wait_drain(200);

        // Reconfigure with bytes buffered
        tbr_en = 1'b0;
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        wait_level(2, 40);
        cw0       = cfg_writes;
        br_cfg    = 2'b11;
        run_model = 1'b0;
        for (int i = 0; i < 20 && !run_model; i++) begin
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        #3;
        check("cfg_done after reconfig", int'(cfg_done), 1);
        check("reconfig write count", cfg_writes - cw0, 2);
        check("level kept across reconfig", int'(fifo_level), 2);
        tbr_en = 1'b1;
        wait_drain(50);

        // Reset in the middle of a write
        tbr_en = 1'b0;
        for (int b = 0; b < 3; b++) push_byte(8'hA0 + 8'(b));
        wait_level(3, 40);
        tbr_en = 1'b1;
        @(negedge clk);
        #2;
        check("write in progress", int'(classify()), int'(K_WR));
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("iocs drops in reset", int'(bus.iocs), 0);
        check("fifo cleared by reset", int'(fifo_level), 0);
        check("cfg_done cleared by reset", int'(cfg_done), 0);
        flush();
        tbr_en = 1'b0;
        br_cfg = 2'b01;
        repeat (2) @(posedge clk);
        release_reset();
        tbr_en = 1'b1;
        push_byte(8'h7E);
        wait_drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_seq.md
SPART_SEQ -- requirements
Module: spart_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, echo buffer depth in bytes; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-005 iocs  output  1  SPART chip select; high only during a bus access cycle.
REQ-006 iorw  output  1  1=read from SPART, 0=write to SPART.
REQ-007 ioaddr  output  2  00=TX/RX buffer, 01=status, 10=divisor low, 11=divisor high.
REQ-008 rda  input  1  SPART receive data available.
REQ-009 tbr  input  1  SPART transmit buffer ready.
REQ-010 databus  inout  8  SPART data bus; driven by spart_seq only when iocs=1 and iorw=0, else high-Z.
REQ-011 cfg_done  output  1  high once the divisor for the current br_cfg is loaded.
REQ-012 fifo_level  output  5  echo buffer occupancy, 0..FIFO_DEPTH.

Function
REQ-013 State machine states: CFG_LO, CFG_HI, RUN; exactly one bus access per cycle at most.
REQ-014 CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0]; next state CFG_HI.
REQ-015 CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; next state RUN; cfg_done set on entry to RUN.
REQ-016 Divisor from br_cfg: 00->16'h0515, 01->16'h028A, 10->16'h0145, 11->16'h00A2.
REQ-017 br_cfg registered each cycle; a change seen in RUN clears cfg_done and moves to CFG_LO the next cycle; a change during CFG_LO/CFG_HI restarts at CFG_LO after CFG_HI completes.
REQ-018 RUN read: when rda=1, fifo not full, no read in previous cycle -> iocs=1, iorw=1, ioaddr=00; databus captured into fifo at that posedge.
REQ-019 RUN write: when tbr=1, fifo not empty, no write in previous cycle, read not issued -> iocs=1, iorw=0, ioaddr=00, databus=fifo head; head popped at that posedge.
REQ-020 Read has priority over write when both are eligible in the same cycle.
REQ-021 One-cycle holdoff after each read (resp. write) covers SPART rda/tbr deassert latency; no back-to-back same-type access.
REQ-022 FIFO full: no read, rda left pending, no byte lost; FIFO empty: no write.
REQ-023 Idle RUN cycle: iocs=0, iorw=1, ioaddr=01, databus high-Z.
REQ-024 FIFO contents and order preserved across reconfiguration; pointers wrap modulo FIFO_DEPTH.
REQ-025 Bytes echoed in arrival order; fifo_level updates the cycle after push/pop, unchanged on neither.

Reset
REQ-026 rst_n low: state=CFG_LO, cfg_done=0, fifo empty (fifo_level=0), holdoff flags clear, iocs=0, databus high-Z, immediately and asynchronously.
REQ-027 First cycle after rst_n release: CFG_LO access for current br_cfg; reset mid-access aborts it with no partial write retained.

Structure
REQ-028 Package spart_pkg SHALL hold state_t enum, ioaddr constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH) and the 4-entry divisor table.
REQ-029 Echo buffer SHALL be a sub-module echo_fifo (push, pop, din, dout, full, empty, level), same clk/rst_n.

Verification
REQ-030 Reset, br_cfg=01 -> cycle 1 write ioaddr=10 data=8'h8A, cycle 2 ioaddr=11 data=8'h02, then cfg_done=1.
REQ-031 RUN, rda pulse with bus=8'h41, tbr=1 -> one read cycle, then one write cycle driving 8'h41; fifo_level 0->1->0.
REQ-032 tbr=0, five rda bytes 8'h01..8'h05 -> four reads, fifo_level=4, 5th held; tbr=1 -> 8'h01..8'h05 written in order.
REQ-033 rda=1 and tbr=1 with fifo non-empty same cycle -> read issued first, write next eligible cycle.
REQ-034 br_cfg 01->11 with 2 bytes buffered -> CFG writes 8'hA2, 8'h00, cfg_done low during them, both bytes later echoed intact.
REQ-035 rst_n asserted mid-write -> iocs=0, databus high-Z same cycle, fifo_level=0, CFG_LO after release.
